idecode: RTL and testbench
==========================

Name: idecode

Overview:
- Instruction-decode stage of the 5-stage MIPS32 pipeline. Sits directly downstream of the fetch stage and consumes its IR/NPC.
- Holds the 32x32 architectural register file, with a write-back port and write-through bypass.
- Sign/zero-extends immediates, selects the destination register and registers everything into the ID/EX pipeline register.
- Detects load-use hazards (stall) and branch flushes (bubble).

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word placed in IR_out for a bubble.
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- IR_in  input  32  instruction from fetch.
- NPC_in  input  32  next-PC from fetch.
- valid_in  input  1  IR_in/NPC_in hold a real instruction.
- flush  input  1  branch taken in EX; squash the instruction currently in ID.
- ex_mem_rd  input  1  the instruction now in EX is a load.
- ex_rd  input  5  destination register of the instruction now in EX.
- wb_en  input  1  write-back enable.
- wb_addr  input  5  write-back register index.
- wb_data  input  32  write-back data.
- stall  output  1  combinational; fetch must hold PC/IR while high.
- A  output  32  registered rs operand.
- B  output  32  registered rt operand.
- Imm  output  32  registered extended immediate.
- NPC_out  output  32  registered NPC_in.
- IR_out  output  32  registered instruction.
- rd_out  output  5  registered destination index.
- reg_wr_out  output  1  registered register-write enable.
- mem_rd_out  output  1  registered load flag.
- mem_wr_out  output  1  registered store flag.
- valid_out  output  1  registered valid.

Behaviour:
- Field extraction:
  - op=IR_in[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Register file:
  - Write on posedge when wb_en && wb_addr!=0.
  - Writes to register 0 are ignored; reads of register 0 always return 0.
- Bypass:
  - If wb_en && wb_addr!=0 && wb_addr==rs (or rt), the read returns wb_data in that same cycle (write-through).
- Immediate:
  - Zero-extend for op 0x0C/0x0D/0x0E (ANDI/ORI/XORI).
  - Sign-extend for every other op.
- Destination and control by op:
  - op 0x00 (R-type): rd_out=rd, reg_wr=1.
  - op 0x23 (LW): rd_out=rt, reg_wr=1, mem_rd=1.
  - op 0x2B (SW): rd_out=0, reg_wr=0, mem_wr=1.
  - op 0x04/0x05 (BEQ/BNE): rd_out=0, reg_wr=0.
  - op 0x02 (J): rd_out=0, reg_wr=0.
  - All other ops (I-type ALU): rd_out=rt, reg_wr=1.
- Stall:
  - stall = valid_in && ex_mem_rd && ex_rd!=0 && (ex_rd==rs || ex_rd==rt) && !flush.
  - Compare rt even for I-type instructions; this is conservative and accepted.
- Bubble:
  - Taken on stall, flush, or valid_in=0.
  - IR_out=NOP_WORD, valid_out=0, reg_wr_out=0, mem_rd_out=0, mem_wr_out=0, rd_out=0.
  - A/B/Imm/NPC_out load zero.
- Normal:
  - All outputs load the decoded values one cycle after the inputs are presented; valid_out=1.
- Priority, highest first:
  - rst.
  - flush (clears any stall the same cycle).
  - stall.
  - normal.
- Write-back vs. rst:
  - wb_en concurrent with rst is ignored; reset wins.
- Stall duration:
  - A load-use stall lasts exactly one cycle under normal operation: the next cycle EX holds the bubble, so ex_mem_rd=0.
  - The block keeps no internal stall state. Upstream holding IR_in/NPC_in stable is sufficient.
- Reset (synchronous):
  - All 32 registers are cleared to 0.
  - All registered outputs are cleared to 0; IR_out=NOP_WORD.
  - stall follows its equation but is forced 0 while rst=1.
  - A reset mid-stall drops the stalled instruction.

Test Plan:
- Reset, then write r5=0x0000_00AA via WB. Next present ADD r3,r5,r0 (0x00A0_1820) -> A=0xAA, B=0, rd_out=3, reg_wr_out=1, valid_out=1 one cycle later.
- Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0x1234_5678, with IR_in using rs=7 -> A=0x1234_5678 next cycle.
- Write to r0: wb_addr=0, wb_data=0xFFFF_FFFF, then read r0 -> A=0.
- Immediates: ADDI r1,r0,0xFFFC -> Imm=0xFFFF_FFFC. ORI r1,r0,0xFFFC -> Imm=0x0000_FFFC. SW -> reg_wr_out=0, mem_wr_out=1.
- Load-use: ex_mem_rd=1, ex_rd=4, IR_in rs=4 -> stall=1 that cycle; next cycle IR_out=NOP_WORD, valid_out=0. Deassert ex_mem_rd -> stall=0 and the instruction issues.
- Flush: flush=1 together with a load-use condition -> stall=0, bubble loaded. Then assert rst mid-stream -> all outputs zero and a previously written register reads 0.

Source files
------------

// File: rtl/idecode.sv
// idecode: MIPS32 decode stage with register file, load-use stall, flush bubble and ID/EX register
module idecode #(
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_in,
  input  logic [31:0] NPC_in,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        ex_mem_rd,
  input  logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] Imm,
  output logic [31:0] NPC_out,
  output logic [31:0] IR_out,
  output logic [4:0]  rd_out,
  output logic        reg_wr_out,
  output logic        mem_rd_out,
  output logic        mem_wr_out,
  output logic        valid_out
);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        valid;
  } idex_t;
  logic [31:0] rf_q [REG_COUNT];
  idex_t       idex_d, idex_q;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;
  logic        is_r, is_lw, is_sw, no_wr, zext, bubble;
  always_comb begin
    op     = IR_in[31:26];
    rs     = IR_in[25:21];
    rt     = IR_in[20:16];
    rd     = IR_in[15:11];
    imm    = IR_in[15:0];
    rs_val = rs == 5'd0 ? 32'd0 : (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
    rt_val = rt == 5'd0 ? 32'd0 : (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
    is_r   = op == 6'h00;
    is_lw  = op == 6'h23;
    is_sw  = op == 6'h2B;
    no_wr  = is_sw || op == 6'h04 || op == 6'h05 || op == 6'h02;
    zext   = op == 6'h0C || op == 6'h0D || op == 6'h0E;
    stall  = !rst && valid_in && ex_mem_rd && ex_rd != 5'd0 && (ex_rd == rs || ex_rd == rt) && !flush;
    bubble = stall || flush || !valid_in;
    idex_d    = '0;
    idex_d.ir = NOP_WORD;
    if (!bubble) begin
      idex_d.a      = rs_val;
      idex_d.b      = rt_val;
      idex_d.imm    = zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
      idex_d.npc    = NPC_in;
      idex_d.ir     = IR_in;
      idex_d.rd     = is_r ? rd : no_wr ? 5'd0 : rt;
      idex_d.reg_wr = !no_wr;
      idex_d.mem_rd = is_lw;
      idex_d.mem_wr = is_sw;
      idex_d.valid  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      idex_q.ir <= NOP_WORD;
    end else begin
      idex_q <= idex_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end
  assign A          = idex_q.a;
  assign B          = idex_q.b;
  assign Imm        = idex_q.imm;
  assign NPC_out    = idex_q.npc;
  assign IR_out     = idex_q.ir;
  assign rd_out     = idex_q.rd;
  assign reg_wr_out = idex_q.reg_wr;
  assign mem_rd_out = idex_q.mem_rd;
  assign mem_wr_out = idex_q.mem_wr;
  assign valid_out  = idex_q.valid;
endmodule

// File: tb/tb_idecode.sv
// tb_idecode: directed self-checking bench for the decode stage
module tb_idecode;
  logic        clk = 1'b0;
  logic        rst, valid_in, flush, ex_mem_rd, wb_en;
  logic [31:0] IR_in, NPC_in, wb_data;
  logic [4:0]  ex_rd, wb_addr;
  logic        stall, reg_wr_out, mem_rd_out, mem_wr_out, valid_out;
  logic [31:0] A, B, Imm, NPC_out, IR_out;
  logic [4:0]  rd_out;
  int          tests = 0;
  int          fails = 0;
  idecode dut (
    .clk(clk), .rst(rst), .IR_in(IR_in), .NPC_in(NPC_in), .valid_in(valid_in),
    .flush(flush), .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .A(A), .B(B), .Imm(Imm),
    .NPC_out(NPC_out), .IR_out(IR_out), .rd_out(rd_out), .reg_wr_out(reg_wr_out),
    .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .valid_out(valid_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pres(input logic [31:0] ir, input logic [31:0] npc);
    IR_in    = ir;
    NPC_in   = npc;
    valid_in = 1'b1;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    pres(32'h0085_3000, 32'h100);
    ex_mem_rd = 1'b1; ex_rd = 5'd4;
    #1;
    chk("stall_forced_low_in_reset", {31'd0, stall}, 32'd0);
    tick();
    chk("rst_ir_out", IR_out, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_a", A, 32'd0);
    rst = 1'b0; ex_mem_rd = 1'b0; valid_in = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00AA;
    tick();
    chk("invalid_in_bubble", {31'd0, valid_out}, 32'd0);
    wb_en = 1'b0;
    pres(32'h00A0_1820, 32'h104);
    tick();
    chk("add_a", A, 32'hAA);
    chk("add_b", B, 32'd0);
    chk("add_rd", {27'd0, rd_out}, 32'd3);
    chk("add_reg_wr", {31'd0, reg_wr_out}, 32'd1);
    chk("add_valid", {31'd0, valid_out}, 32'd1);
    chk("add_npc", NPC_out, 32'h104);
    chk("add_ir", IR_out, 32'h00A0_1820);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
    pres(32'h00E5_0800, 32'h108);
    tick();
    chk("bypass_a", A, 32'h1234_5678);
    chk("bypass_b", B, 32'hAA);
    wb_en = 1'b0;
    tick();
    chk("r7_stored", A, 32'h1234_5678);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    pres(32'h0000_0800, 32'h10C);
    tick();
    chk("r0_no_bypass", A, 32'd0);
    wb_en = 1'b0;
    tick();
    chk("r0_reads_zero", A, 32'd0);
    pres(32'h2001_FFFC, 32'h110);
    tick();
    chk("addi_imm_sext", Imm, 32'hFFFF_FFFC);
    chk("addi_rd", {27'd0, rd_out}, 32'd1);
    pres(32'h3401_FFFC, 32'h114);
    tick();
    chk("ori_imm_zext", Imm, 32'h0000_FFFC);
    pres(32'hACE5_0004, 32'h118);
    tick();
    chk("sw_reg_wr", {31'd0, reg_wr_out}, 32'd0);
    chk("sw_mem_wr", {31'd0, mem_wr_out}, 32'd1);
    chk("sw_rd", {27'd0, rd_out}, 32'd0);
    chk("sw_a", A, 32'h1234_5678);
    pres(32'h8CA2_FFF8, 32'h11C);
    tick();
    chk("lw_rd", {27'd0, rd_out}, 32'd2);
    chk("lw_mem_rd", {31'd0, mem_rd_out}, 32'd1);
    chk("lw_reg_wr", {31'd0, reg_wr_out}, 32'd1);
    chk("lw_imm", Imm, 32'hFFFF_FFF8);
    pres(32'h10A7_0003, 32'h120);
    tick();
    chk("beq_reg_wr", {31'd0, reg_wr_out}, 32'd0);
    chk("beq_rd", {27'd0, rd_out}, 32'd0);
    chk("beq_mem_rd", {31'd0, mem_rd_out}, 32'd0);
    ex_mem_rd = 1'b1; ex_rd = 5'd4;
    pres(32'h0085_3000, 32'h124);
    #1;
    chk("loaduse_stall_rs", {31'd0, stall}, 32'd1);
    tick();
    chk("stall_bubble_ir", IR_out, 32'h0);
    chk("stall_bubble_valid", {31'd0, valid_out}, 32'd0);
    chk("stall_bubble_rd", {27'd0, rd_out}, 32'd0);
    ex_mem_rd = 1'b0;
    #1;
    chk("stall_released", {31'd0, stall}, 32'd0);
    tick();
    chk("reissue_ir", IR_out, 32'h0085_3000);
    chk("reissue_valid", {31'd0, valid_out}, 32'd1);
    chk("reissue_rd", {27'd0, rd_out}, 32'd6);
    chk("reissue_b", B, 32'hAA);
    ex_mem_rd = 1'b1; ex_rd = 5'd5;
    #1;
    chk("loaduse_stall_rt", {31'd0, stall}, 32'd1);
    ex_rd = 5'd0;
    pres(32'h0000_0800, 32'h128);
    #1;
    chk("no_stall_ex_rd0", {31'd0, stall}, 32'd0);
    ex_rd = 5'd4;
    pres(32'h0085_3000, 32'h12C);
    valid_in = 1'b0;
    #1;
    chk("no_stall_invalid", {31'd0, stall}, 32'd0);
    valid_in = 1'b1; flush = 1'b1;
    #1;
    chk("flush_kills_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_bubble_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_bubble_ir", IR_out, 32'h0);
    flush = 1'b0; ex_mem_rd = 1'b0;
    pres(32'h00E5_0800, 32'h130);
    tick();
    chk("pre_rst_a", A, 32'h1234_5678);
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick();
    chk("midrst_a", A, 32'd0);
    chk("midrst_valid", {31'd0, valid_out}, 32'd0);
    chk("midrst_npc", NPC_out, 32'd0);
    rst = 1'b0; wb_en = 1'b0;
    pres(32'h0125_0800, 32'h134);
    tick();
    chk("r9_wb_in_rst_dropped", A, 32'd0);
    chk("r5_cleared_by_rst", B, 32'd0);
    pres(32'h00E0_0800, 32'h138);
    tick();
    chk("r7_cleared_by_rst", A, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
